stream_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready stream channel (the input side of the skid buffer) among N requesters. Each requester presents a packet as a sequence of beats terminated by `s_last`. Once a requester wins, it holds the channel until its last beat is accepted. The block sits directly upstream of the skid buffer and has zero-cycle latency from the granted input to the output.

---
 rtl/stream_rr_arbiter.sv | 105 ++++++++++
 tb/tb_stream_rr_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among N packet requesters.
// A winner holds the channel until its last beat is accepted; data path is purely combinational.
module stream_rr_arbiter #(
  parameter int N  = 4,
  parameter int W  = 3,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    s_valid,
  input  logic [N*W-1:0]  s_data,
  input  logic [N-1:0]    s_last,
  output logic [N-1:0]    s_ready,
  output logic            m_valid,
  output logic [W-1:0]    m_data,
  output logic            m_last,
  output logic [SW-1:0]   m_src,
  input  logic            m_ready,
  output logic            busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] gnt_q;
  logic [SW-1:0] win;
  logic [SW-1:0] cand;
  logic [SW-1:0] sel;
  logic          found;
  logic [W-1:0]  beat [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign beat[i] = s_data[i*W +: W];
  end

  function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] idx);
    return (idx == SW'(N-1)) ? '0 : idx + 1'b1;
  endfunction

  // Rotating search starting at ptr; candidates are reduced mod N so indices >= N never win.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = SW'((32'(ptr) + k) % N);
      if (!found && s_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign sel  = (state == LOCKED) ? gnt_q : win;
  assign busy = (state == LOCKED);

  always_comb begin
    s_ready = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    m_src   = '0;
    if (reset_n) begin
      if (state == LOCKED || found) begin
        m_valid      = s_valid[sel];
        m_data       = beat[sel];
        m_last       = s_last[sel];
        m_src        = sel;
        s_ready[sel] = m_ready;
      end else begin
        m_src = ptr;
      end
    end
  end

  // A stalled winner is locked too, so a later higher-priority arrival cannot displace it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
      gnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            if (m_ready && s_last[win]) begin
              ptr <= next_idx(win);
            end else begin
              state <= LOCKED;
              gnt_q <= win;
            end
          end
        end
        LOCKED: begin
          if (m_valid && m_ready && m_last) begin
            state <= IDLE;
            ptr   <= next_idx(gnt_q);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a packet-level priority model.
module tb_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 3;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   s_valid = '0;
  logic [N*W-1:0] s_data = '0;
  logic [N-1:0]   s_last = '0;
  logic [N-1:0]   s_ready;
  logic           m_valid;
  logic [W-1:0]   m_data;
  logic           m_last;
  logic [SW-1:0]  m_src;
  logic           m_ready = 1'b0;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.N(N), .W(W), .SW(SW)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_src(m_src),
    .m_ready(m_ready), .busy(busy)
  );

  // Model: who owns the channel (if anyone) and who is first in line.
  bit             mlocked = 1'b0;
  int             mowner  = 0;
  int             mprio   = 0;
  logic           e_valid = 1'b0;
  logic           e_last  = 1'b0;
  logic           e_busy  = 1'b0;
  logic [W-1:0]   e_data  = '0;
  int             e_src   = 0;
  logic [N-1:0]   e_ready = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    int sel;
    int bestd;
    e_valid = 1'b0; e_data = '0; e_last = 1'b0; e_src = 0; e_ready = '0; e_busy = 1'b0;
    if (!reset_n) return;
    e_busy = mlocked;
    if (mlocked) begin
      sel = mowner;
    end else begin
      sel = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
        if (s_valid[i] && ((i - mprio + N) % N) < bestd) begin
          bestd = (i - mprio + N) % N;
          sel = i;
        end
      end
      if (sel < 0) begin
        e_src = mprio;
        return;
      end
    end
    e_valid      = s_valid[sel];
    e_data       = s_data[sel*W +: W];
    e_last       = s_last[sel];
    e_src        = sel;
    e_ready[sel] = m_ready;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mlocked <= 1'b0;
      mowner  <= 0;
      mprio   <= 0;
    end else if (!mlocked) begin
      if (e_valid) begin
        if (m_ready && e_last) begin
          mprio <= (e_src + 1) % N;
        end else begin
          mlocked <= 1'b1;
          mowner  <= e_src;
        end
      end
    end else if (e_valid && m_ready && e_last) begin
      mlocked <= 1'b0;
      mprio   <= (mowner + 1) % N;
    end
  end

  task automatic check_all();
    model_eval();
    chk("m_valid", 32'(m_valid), 32'(e_valid));
    chk("m_data",  32'(m_data),  32'(e_data));
    chk("m_last",  32'(m_last),  32'(e_last));
    chk("m_src",   32'(m_src),   32'(e_src));
    chk("s_ready", 32'(s_ready), 32'(e_ready));
    chk("busy",    32'(busy),    32'(e_busy));
  endtask

  task automatic step(input logic rn, input logic [N-1:0] v, input logic [N*W-1:0] d,
                      input logic [N-1:0] l, input logic mr);
    @(negedge clk);
    reset_n = rn; s_valid = v; s_data = d; s_last = l; m_ready = mr;
    #1;
    check_all();
  endtask

  function automatic logic [N*W-1:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {W'(d3), W'(d2), W'(d1), W'(d0)};
  endfunction

  initial begin
    int wins[5];
    wins = '{0, 1, 2, 3, 0};

    step(1'b0, 4'b1111, pk(1, 2, 3, 4), 4'b1111, 1'b1);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_m_src", 32'(m_src), 0);

    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b1111, pk(1, 2, 3, 4), 4'b1111, 1'b1);
      chk("rr_src", 32'(m_src), 32'(wins[k]));
      chk("rr_data", 32'(m_data), 32'(wins[k] + 1));
    end

    for (int d = 5; d <= 7; d++) begin
      step(1'b1, 4'b0100, pk(0, 0, d, 0), 4'b0100, 1'b1);
      chk("single_src", 32'(m_src), 2);
      chk("single_data", 32'(m_data), 32'(d));
      chk("single_busy", 32'(busy), 0);
    end

    step(1'b1, 4'b0001, pk(7, 0, 0, 0), 4'b0001, 1'b1);
    chk("pre_lock_src", 32'(m_src), 0);

    step(1'b1, 4'b0011, pk(6, 1, 0, 0), 4'b0000, 1'b1);
    chk("lock_b1_src", 32'(m_src), 1);
    chk("lock_b1_data", 32'(m_data), 1);
    step(1'b1, 4'b0011, pk(6, 2, 0, 0), 4'b0000, 1'b1);
    chk("lock_b2_src", 32'(m_src), 1);
    chk("lock_b2_busy", 32'(busy), 1);
    step(1'b1, 4'b0011, pk(6, 3, 0, 0), 4'b0010, 1'b1);
    chk("lock_b3_data", 32'(m_data), 3);
    chk("lock_b3_busy", 32'(busy), 1);
    step(1'b1, 4'b0001, pk(6, 0, 0, 0), 4'b0001, 1'b1);
    chk("after_lock_src", 32'(m_src), 0);
    chk("after_lock_busy", 32'(busy), 0);

    step(1'b1, 4'b1000, pk(0, 0, 0, 4), 4'b1000, 1'b0);
    chk("bp_src0", 32'(m_src), 3);
    chk("bp_ready0", 32'(s_ready), 0);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 4'b1001, pk(5, 0, 0, 4), 4'b1001, 1'b0);
      chk("bp_src", 32'(m_src), 3);
      chk("bp_data", 32'(m_data), 4);
    end
    step(1'b1, 4'b1001, pk(5, 0, 0, 4), 4'b1001, 1'b1);
    chk("bp_rel_ready", 32'(s_ready), 32'(4'b1000));
    step(1'b1, 4'b0001, pk(5, 0, 0, 0), 4'b0001, 1'b1);
    chk("bp_next_src", 32'(m_src), 0);

    step(1'b1, 4'b0100, pk(0, 0, 1, 0), 4'b0100, 1'b1);
    step(1'b1, 4'b1001, pk(2, 0, 0, 3), 4'b1001, 1'b1);
    chk("wrap_src3", 32'(m_src), 3);
    step(1'b1, 4'b1001, pk(2, 0, 0, 3), 4'b1001, 1'b1);
    chk("wrap_src0", 32'(m_src), 0);
    chk("wrap_data0", 32'(m_data), 2);

    step(1'b1, 4'b0010, pk(0, 5, 0, 0), 4'b0000, 1'b1);
    chk("mid_b1_src", 32'(m_src), 1);
    step(1'b1, 4'b0010, pk(0, 6, 0, 0), 4'b0000, 1'b1);
    chk("mid_b2_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    step(1'b1, 4'b0100, pk(0, 0, 3, 0), 4'b0100, 1'b1);
    chk("post_rst_src", 32'(m_src), 2);
    chk("post_rst_valid", 32'(m_valid), 1);

    for (int c = 0; c < 3000; c++) begin
      step(logic'($urandom_range(0, 199) != 0), N'($urandom), (N*W)'($urandom),
           N'($urandom), logic'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
